// File: rtl/reg_file_2r1w_pkg.sv
// Shared constants for the register-file slice: default geometry and a depth helper.
package reg_file_pkg;

   localparam int RF_WIDTH  = 32;
   localparam int RF_ADDR_W = 5;
   localparam int RF_DEPTH  = 2 ** RF_ADDR_W;

   function automatic int rf_depth(input int addr_w);
      return 1 << addr_w;
   endfunction

endpackage

// File: rtl/reg_file_2r1w_if.sv
// Bus bundle for the 2-read / 1-write register file: one write port, two registered read ports.
interface reg_file_2r1w_if
   import reg_file_pkg::*;
#(
   parameter int WIDTH  = RF_WIDTH,
   parameter int ADDR_W = RF_ADDR_W
);

   logic              WE;
   logic [ADDR_W-1:0] WADDR;
   logic [WIDTH-1:0]  WDATA;
   logic              RE1;
   logic [ADDR_W-1:0] RADDR1;
   logic [WIDTH-1:0]  RDATA1;
   logic              RE2;
   logic [ADDR_W-1:0] RADDR2;
   logic [WIDTH-1:0]  RDATA2;

   modport master (
      output WE, WADDR, WDATA, RE1, RADDR1, RE2, RADDR2,
      input  RDATA1, RDATA2
   );

   modport slave (
      input  WE, WADDR, WDATA, RE1, RADDR1, RE2, RADDR2,
      output RDATA1, RDATA2
   );

endinterface

// File: rtl/reg_file_2r1w_decoder_n.sv
// N-to-2**N one-hot decoder used to turn the write address into per-word select lines.
module decoder_n #(
   parameter int N = 5
) (
   input  logic [N-1:0]        sel,
   output logic [(2**N)-1:0]   onehot
);

   genvar gi;
   generate
      for (gi = 0; gi < 2 ** N; gi++) begin : g_line
         assign onehot[gi] = (sel == N'(gi));
      end
   endgenerate

endmodule

// File: rtl/reg_file_2r1w.sv
// Parametrised register bank: DEPTH x WIDTH storage, one synchronous write port,
// two registered read ports with optional write bypass and hard-wired zero word.
module reg_file_2r1w
   import reg_file_pkg::*;
#(
   parameter int               WIDTH         = RF_WIDTH,
   parameter int               ADDR_W        = RF_ADDR_W,
   parameter logic [WIDTH-1:0] RESET_PATTERN = '0,
   parameter bit               ZERO_REG      = 1'b1,
   parameter bit               BYPASS        = 1'b1
) (
   input  logic           CLK,
   input  logic           RESET,
   reg_file_2r1w_if.slave bus
);

   localparam int DEPTH = rf_depth(ADDR_W);

   logic [DEPTH-1:0]             dec;
   logic [DEPTH-1:0]             load;
   logic [DEPTH-1:0][WIDTH-1:0]  words;

   decoder_n #(.N(ADDR_W)) u_dec (
      .sel    (bus.WADDR),
      .onehot (dec)
   );

   // Word 0 never loads when it is the zero register, so it stays at its reset value of 0.
   assign load = dec & {DEPTH{bus.WE}} & ~DEPTH'(ZERO_REG);

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_word
         localparam logic [WIDTH-1:0] INIT = (ZERO_REG && gi == 0) ? '0 : RESET_PATTERN;
         logic [WIDTH-1:0] word_reg;

         always_ff @(posedge CLK or negedge RESET) begin
            if (!RESET) begin
               word_reg <= INIT;
            end else if (load[gi]) begin
               word_reg <= bus.WDATA;
            end
         end

         assign words[gi] = word_reg;
      end
   endgenerate

   logic [1:0]                re;
   logic [1:0][ADDR_W-1:0]    raddr;
   logic [1:0][WIDTH-1:0]     rdata_reg;

   assign re    = {bus.RE2, bus.RE1};
   assign raddr = {bus.RADDR2, bus.RADDR1};

   generate
      for (gi = 0; gi < 2; gi++) begin : g_rd
         logic [WIDTH-1:0] rdata_next;

         // Priority: zero register beats bypass, bypass beats stored contents.
         always_comb begin
            rdata_next = words[raddr[gi]];
            if (BYPASS && bus.WE && (bus.WADDR == raddr[gi])) begin
               rdata_next = bus.WDATA;
            end
            if (ZERO_REG && (raddr[gi] == '0)) begin
               rdata_next = '0;
            end
         end

         always_ff @(posedge CLK or negedge RESET) begin
            if (!RESET) begin
               rdata_reg[gi] <= '0;
            end else if (re[gi]) begin
               rdata_reg[gi] <= rdata_next;
            end
         end
      end
   endgenerate

   assign bus.RDATA1 = rdata_reg[0];
   assign bus.RDATA2 = rdata_reg[1];

endmodule
